// File: rtl/pipeline_reg_nslot_pkg.sv
// Shared definitions for the N-slot pipeline register: width helpers and
// latency-insensitive (valid/backpressure) handshake helpers.
package pipeline_reg_nslot_pkg;

    // Smallest r such that (1 << r) >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Pointer width for a modulo-depth counter; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    // A token moves across an LI channel when it is valid and not backpressured.
    function automatic logic li_xfer(input logic valid, input logic bp);
        return valid & ~bp;
    endfunction

endpackage

// File: rtl/pipeline_wrap_ctr.sv
// Modulo-Depth pointer: increments on inc, wraps from Depth-1 back to 0,
// cleared by the asynchronous active-low reset.
module pipeline_wrap_ctr
    import pipeline_reg_nslot_pkg::*;
#(
    parameter int Depth = 4,
    parameter int PW    = ptr_width(Depth)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] Last = PW'(Depth - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == Last) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/pipeline_reg_nslot.sv
// N-slot circular-buffer pipeline register on an LI channel, with occupancy
// and almost-full status. Optional macro: PIPELINE_REG_BP_PASSTHRU_EN.
module pipeline_reg_nslot
    import pipeline_reg_nslot_pkg::*;
#(
    parameter int Width      = 8,
    parameter int Depth      = 4,
    parameter int AlmostFull = Depth - 1,
    localparam int CW        = clog2(Depth + 1),
    localparam int PW        = ptr_width(Depth)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [Width-1:0] d,
    input  logic             d_valid,
    output logic             d_bp,
    output logic [Width-1:0] q,
    output logic             q_valid,
    input  logic             q_bp,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam logic [CW-1:0] DepthC = CW'(Depth);
    localparam logic [CW-1:0] AfullC = CW'(AlmostFull);

    logic [Width-1:0] slot_q [Depth];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             full_q;
    logic             push;
    logic             pop;

    // Handshake: a token transfers on a channel in the cycle where its valid
    // is 1 and its bp is 0; valid and data hold steady while bp is 1, and bp
    // never depends on valid of the same channel.
    assign push = li_xfer(d_valid, d_bp);
    assign pop  = li_xfer(q_valid, q_bp);

`ifdef PIPELINE_REG_BP_PASSTHRU_EN
    // A full buffer still accepts when the head leaves in the same cycle.
    assign d_bp = full_q & q_bp;
`else
    assign d_bp = full_q;
`endif

    assign q_valid     = (count_q != '0);
    assign q           = slot_q[head];
    assign count       = count_q;
    assign almost_full = (count_q >= AfullC);

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Count is held separately from the pointers so full and empty stay
    // unambiguous when Depth is not a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == DepthC);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < Depth; i++) begin
                slot_q[i] <= '0;
            end
        end else if (push) begin
            slot_q[tail] <= d;
        end
    end

    pipeline_wrap_ctr #(
        .Depth (Depth),
        .PW    (PW)
    ) u_head_ctr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (pop),
        .ptr    (head)
    );

    pipeline_wrap_ctr #(
        .Depth (Depth),
        .PW    (PW)
    ) u_tail_ctr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (push),
        .ptr    (tail)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (resetn) begin
            assert (count_q <= DepthC)
                else $error("pipeline_reg_nslot: count %0d exceeds depth %0d", count_q, Depth);
            assert (Depth >= 1 && Depth <= 256 && AlmostFull >= 1 && AlmostFull <= Depth)
                else $error("pipeline_reg_nslot: illegal Depth %0d / AlmostFull %0d", Depth, AlmostFull);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_reg_nslot.sv
// Directed bench for pipeline_reg_nslot: depth-4 fill/drain/reset, depth-3
// streaming and random backpressure, depth-1 throughput (both builds).
module tb_pipeline_reg_nslot;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [7:0] d4, q4, d3, q3, d1, q1;
    logic       dv4, dbp4, qv4, qbp4, af4;
    logic       dv3, dbp3, qv3, qbp3, af3;
    logic       dv1, dbp1, qv1, qbp1, af1;
    logic [2:0] count4;
    logic [1:0] count3;
    logic [0:0] count1;

    pipeline_reg_nslot #(.Width(8), .Depth(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .d(d4), .d_valid(dv4), .d_bp(dbp4),
        .q(q4), .q_valid(qv4), .q_bp(qbp4), .count(count4), .almost_full(af4)
    );

    pipeline_reg_nslot #(.Width(8), .Depth(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .d(d3), .d_valid(dv3), .d_bp(dbp3),
        .q(q3), .q_valid(qv3), .q_bp(qbp3), .count(count3), .almost_full(af3)
    );

    pipeline_reg_nslot #(.Width(8), .Depth(1), .AlmostFull(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .d(d1), .d_valid(dv1), .d_bp(dbp1),
        .q(q1), .q_valid(qv1), .q_bp(qbp1), .count(count1), .almost_full(af1)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] fill_vals [4];
        int         nxt;
        int         outs;
        int         sz;
        logic       exp_dbp;

        fill_vals[0] = 8'h11;
        fill_vals[1] = 8'h22;
        fill_vals[2] = 8'h33;
        fill_vals[3] = 8'h44;

        resetn = 1'b0;
        d4 = '0; dv4 = 0; qbp4 = 0;
        d3 = '0; dv3 = 0; qbp3 = 0;
        d1 = '0; dv1 = 0; qbp1 = 0;
        tick();
        tick();
        settle();
        chk("rst_q", q4, 8'h00);
        chk("rst_qvalid", qv4, 0);
        chk("rst_count", count4, 0);
        chk("rst_dbp", dbp4, 0);
        chk("rst_afull", af4, 0);
        chk("rst_count3", count3, 0);
        chk("rst_qvalid1", qv1, 0);
        resetn = 1'b1;
        tick();

        // Fill depth-4 with downstream stalled.
        qbp4 = 1;
        for (int i = 0; i < 4; i++) begin
            d4 = fill_vals[i];
            dv4 = 1;
            settle();
            chk("fill_dbp_pre", dbp4, 0);
            tick();
            chk("fill_count", count4, i + 1);
            chk("fill_afull", af4, (i + 1 >= 3));
            chk("fill_head", q4, 8'h11);
            chk("fill_qvalid", qv4, 1);
        end
        chk("full_dbp", dbp4, 1);

        // Extra token while full must be refused.
        d4 = 8'h55;
        dv4 = 1;
        tick();
        chk("full_count", count4, 4);
        chk("full_dbp_hold", dbp4, 1);

        // Drain in order.
        dv4 = 0;
        qbp4 = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_q", q4, fill_vals[i]);
            chk("drain_qvalid", qv4, 1);
            tick();
            chk("drain_count", count4, 3 - i);
            chk("drain_dbp", dbp4, 0);
        end
        chk("drain_empty", qv4, 0);
        chk("drain_afull", af4, 0);

        // Async reset mid-stream with two tokens held.
        qbp4 = 1;
        d4 = 8'h61; dv4 = 1;
        tick();
        d4 = 8'h62;
        tick();
        dv4 = 0;
        settle();
        chk("pre_rst_count", count4, 2);
        settle();
        resetn = 1'b0;
        settle();
        chk("async_rst_qvalid", qv4, 0);
        chk("async_rst_count", count4, 0);
        chk("async_rst_dbp", dbp4, 0);
        chk("async_rst_q", q4, 8'h00);
        settle();
        resetn = 1'b1;
        tick();
        d4 = 8'hA5; dv4 = 1;
        settle();
        chk("post_rst_pre_qvalid", qv4, 0);
        tick();
        dv4 = 0;
        chk("post_rst_q", q4, 8'hA5);
        chk("post_rst_qvalid", qv4, 1);
        chk("post_rst_count", count4, 1);
        qbp4 = 0;
        tick();
        chk("post_rst_drain", count4, 0);

        // Depth-3 streaming: one token per cycle, wrap seen repeatedly.
        exp_q.delete();
        qbp3 = 0;
        nxt = 1;
        outs = 0;
        for (int c = 0; c < 110; c++) begin
            dv3 = (nxt <= 100);
            d3 = nxt[7:0];
            settle();
            sz = exp_q.size();
            chk("stream_count", count3, sz);
            chk("stream_qvalid", qv3, (sz != 0));
            chk("stream_dbp", dbp3, 0);
            if (sz != 0) begin
                chk("stream_q", q3, exp_q[0]);
                void'(exp_q.pop_front());
                outs++;
            end
            if (dv3) begin
                exp_q.push_back(d3);
                nxt++;
            end
            tick();
        end
        dv3 = 0;
        chk("stream_outs", outs, 100);

        // Depth-3 random valid/backpressure against the reference queue.
        for (int c = 0; c < 10000; c++) begin
            dv3 = 1'($urandom_range(0, 1));
            qbp3 = 1'($urandom_range(0, 1));
            d3 = 8'($urandom);
            settle();
            sz = exp_q.size();
`ifdef PIPELINE_REG_BP_PASSTHRU_EN
            exp_dbp = (sz == 3) && qbp3;
`else
            exp_dbp = (sz == 3);
`endif
            chk("rand_count", count3, sz);
            chk("rand_qvalid", qv3, (sz != 0));
            chk("rand_dbp", dbp3, exp_dbp);
            chk("rand_afull", af3, (sz >= 2));
            if (sz != 0) begin
                chk("rand_q", q3, exp_q[0]);
                if (!qbp3) begin
                    void'(exp_q.pop_front());
                end
            end
            if (dv3 && !exp_dbp) begin
                exp_q.push_back(d3);
            end
            tick();
        end
        dv3 = 0;

        // Depth-1 throughput with continuous offer and no backpressure.
        tick();
        qbp3 = 0;
        resetn = 1'b0;
        settle();
        resetn = 1'b1;
        exp_q.delete();
        tick();
        qbp1 = 0;
        nxt = 0;
        outs = 0;
        for (int c = 0; c < 20; c++) begin
            dv1 = 1;
            d1 = nxt[7:0];
            settle();
            sz = exp_q.size();
`ifdef PIPELINE_REG_BP_PASSTHRU_EN
            exp_dbp = (sz == 1) && qbp1;
`else
            exp_dbp = (sz == 1);
`endif
            chk("d1_dbp", dbp1, exp_dbp);
            chk("d1_qvalid", qv1, (sz != 0));
            if (sz != 0) begin
                chk("d1_q", q1, exp_q[0]);
                void'(exp_q.pop_front());
                outs++;
            end
            if (!exp_dbp) begin
                exp_q.push_back(d1);
                nxt++;
            end
            tick();
        end
        dv1 = 0;
`ifdef PIPELINE_REG_BP_PASSTHRU_EN
        chk("d1_outs", outs, 19);
`else
        chk("d1_outs", outs, 10);
`endif

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_reg_nslot.md
Name: pipeline_reg_nslot

Overview:
- Parametrised next-generation pipeline register: an N-slot circular buffer on a valid/backpressure (LI) channel.
- Generalises the one-slot and two-slot pipeline registers to any depth >= 1.
- Adds occupancy and almost-full status outputs.
- Used between LI stages where more slack than two tokens is needed, e.g. to absorb the latency of long feedback or backpressure paths.

Parameters:
- Width, 8, data bits per token.
- Depth, 4, number of buffer slots; legal range 1..256; need not be a power of two.
- AlmostFull, Depth-1, occupancy at or above which almost_full asserts; legal range 1..Depth.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- d  input  Width  incoming token data.
- d_valid  input  1  incoming token valid.
- d_bp  output  1  backpressure to the upstream stage; the token is accepted only when d_valid=1 and d_bp=0.
- q  output  Width  head token data.
- q_valid  output  1  head token valid.
- q_bp  input  1  downstream backpressure; the token leaves only when q_valid=1 and q_bp=0.
- count  output  CW  current occupancy, where CW = clog2(Depth+1).
- almost_full  output  1  asserted when count >= AlmostFull.

Behaviour:
- Reset: asynchronous on the resetn falling edge, released synchronously to clk. While resetn=0:
  - head, tail and count = 0.
  - All slot data = 0, so q = 0.
  - q_valid = 0, d_bp = 0, almost_full = 0 (1 only if AlmostFull = 0, which is illegal).
- Definitions: push = d_valid & ~d_bp; pop = q_valid & ~q_bp.
- Storage: Depth registers addressed by head (read) and tail (write). Each pointer increments by 1 and wraps from Depth-1 to 0.
- Outputs:
  - q = slot[head]; q_valid = (count != 0); q is registered with no combinational path from d.
  - d_bp = (count == Depth), a registered decode (default build; see Optional Feature).
- Latency: a token pushed in cycle t appears on q with q_valid=1 in cycle t+1 if the buffer was empty. No combinational bypass from d to q.
- Push only: write slot[tail]=d, tail++, count++.
- Pop only: head++, count--.
- Push and pop together (possible only when 0 < count < Depth in the default build): write, tail++, head++, count unchanged. Full throughput is sustained indefinitely.
- Full (count == Depth): d_bp=1; d_valid is ignored and no slot is written.
- Empty (count == 0): q_valid=0; q_bp is ignored; head does not move.
- Depth=1: behaves as a single-slot register at 1/2 throughput in the default build.
- Reset mid-operation: all tokens are discarded immediately with no output glitch beyond q_valid falling. Downstream must treat any in-flight handshake as void.
- Assertions (simulation only, under synthesis translate_off):
  - count never exceeds Depth.
  - Parameters are within their legal ranges.

Optional Feature:
- Macro: PIPELINE_REG_BP_PASSTHRU_EN.
- Defined: d_bp = (count == Depth) & q_bp. A full buffer accepts a push in the same cycle it pops, so Depth=1 reaches full throughput. This adds a combinational path from q_bp to d_bp, which integration must time.
- Undefined: d_bp is registered-only as specified above, with no q_bp-to-d_bp path.
- All other behaviour is identical in both builds.

Decomposition:
- Shared include pipeline_defs.vh holds:
  - the clog2 constant function;
  - LI handshake helper macros (push/pop expressions).
- One sub-module, pipeline_wrap_ctr: a modulo-Depth pointer with increment enable and async reset. It is instantiated twice, for head and tail.
- Count is kept as a separate register, not derived from the pointers, so full and empty are unambiguous for non-power-of-two depths.

Test Plan:
- Reset then fill: Depth=4, Width=8; push 0x11, 0x22, 0x33, 0x44 with q_bp=1 -> count 1,2,3,4; almost_full=1 at count 3; d_bp=1 after the 4th push; a 5th value 0x55 is not stored.
- Drain order: after the fill, set q_bp=0 -> q = 0x11, 0x22, 0x33, 0x44 in consecutive cycles; q_valid falls after 0x44; count returns to 0.
- Streaming: Depth=3; push 100 incrementing tokens with q_bp=0 every cycle -> one token out per cycle; first output 1 cycle after the first push; pointer wrap at 2->0 is seen repeatedly with no loss or duplication.
- Random backpressure: d_valid and q_bp each random at 50% for 10k cycles -> a scoreboard matches every token in order; count equals the number of outstanding tokens every cycle.
- Async reset mid-stream: assert resetn=0 between clock edges with count=2 -> q_valid, count and d_bp drop to 0 immediately, without waiting for a clk edge; the first post-reset push of 0xA5 appears next cycle.
- Passthru build: Depth=1 with PIPELINE_REG_BP_PASSTHRU_EN defined; d_valid=1, q_bp=0 continuously -> one token per cycle. Undefined build -> one token every 2 cycles.
